// File: rtl/ah_pktconv_pkg.sv
// rtl/ah_pktconv_pkg.sv - shared FSM encoding and width helper for the packet arbiter
package ah_pktconv_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } pc_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ah_rr_pick.sv
// rtl/ah_rr_pick.sv - stateless round-robin pick: first set request at or after i_ptr, with wrap
module ah_rr_pick
  import ah_pktconv_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx
);

  logic [NREQ-1:0] w_rot;
  int              w_off;
  int              w_sum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = k;
    end
    w_sum = int'(i_ptr) + w_off;
    if (w_sum >= NREQ) w_sum = w_sum - NREQ;
    o_idx    = IW'(w_sum);
    o_onehot = (w_rot != '0) ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/ah_pktconv_arbiter.sv
// rtl/ah_pktconv_arbiter.sv - packet-locked round-robin arbiter feeding one width converter
module ah_pktconv_arbiter
  import ah_pktconv_pkg::*;
#(
  parameter int  NREQ     = 4,
  parameter int  DW       = 32,
  parameter int  MAXBEATS = 64,
  localparam int IW       = clog2w(NREQ),
  localparam int CW       = clog2w(MAXBEATS + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [IW-1:0]      grant_id,
  output logic               busy,
  output logic               err_overlen
);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic [IW-1:0]   r_grant_id;
  logic [IW-1:0]   r_last_grant;
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic [IW-1:0]   w_ptr;
  logic [IW-1:0]   w_pick_idx;
  logic [NREQ-1:0] w_pick_onehot;
  logic            w_pick_any;
  logic            w_locked;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic            w_cap;
  logic            w_xfer;
  logic            w_end;
  logic            w_forced;

  assign w_ptr = (r_last_grant == IW'(NREQ - 1)) ? '0 : r_last_grant + 1'b1;

  ah_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (req_valid),
    .i_ptr    (w_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  assign w_pick_any  = |w_pick_onehot;
  assign w_locked    = (r_state == ST_LOCKED);
  assign w_sel_valid = req_valid[r_grant_id];
  assign w_sel_last  = req_last[r_grant_id];
  // The beat that would reach MAXBEATS is closed as the packet's last.
  assign w_cap       = (r_cnt == CW'(MAXBEATS - 1));

  assign out_data    = req_data[r_grant_id*DW +: DW];
  assign out_valid   = w_locked & w_sel_valid;
  assign out_last    = w_locked & (w_sel_last | w_cap);
  assign req_ready   = w_locked ? (NREQ'(out_ready) << r_grant_id) : '0;
  assign w_xfer      = out_valid & out_ready;
  assign w_end       = w_xfer & out_last;
  assign w_forced    = w_xfer & w_cap & ~w_sel_last;

  assign grant_id    = r_grant_id;
  assign busy        = w_locked;
  assign err_overlen = r_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick_any) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_end) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant_id   <= '0;
      r_last_grant <= IW'(NREQ - 1);
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_forced;
      if (!w_locked && w_pick_any) begin
        r_grant_id <= w_pick_idx;
        r_cnt      <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_end) r_last_grant <= r_grant_id;
      end
    end
  end

endmodule

// File: tb/tb_ah_pktconv_arbiter.sv
// tb/tb_ah_pktconv_arbiter.sv - self-checking bench: vector table, directed corner sequences, random traffic vs model
module tb_ah_pktconv_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_valid, req_last, req_ready;
  logic [DW-1:0]      out_data;
  logic               out_valid, out_last, out_ready;
  logic [1:0]         grant_id;
  logic               busy, err_overlen;

  always #5 clk = ~clk;

  ah_pktconv_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBEATS(MAXB)) dut (
    .clk(clk), .rstn(rstn), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .err_overlen(err_overlen)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: locked flag, granted requester, last grant, beats taken, pending error pulse
  bit m_locked;
  int m_grant, m_last, m_cnt;
  bit m_err;
  int gq[$];
  int n_err_seen;

  // Requester traffic generators
  int plen[NREQ], npk[NREQ], cfg_len[NREQ], bidx[NREQ], pk[NREQ];
  bit en[NREQ];
  bit rnd_mode = 1'b0;
  logic ordy_dir = 1'b1;

  task automatic model_reset();
    m_locked = 1'b0; m_grant = 0; m_last = NREQ - 1; m_cnt = 0; m_err = 1'b0;
    gq.delete();
  endtask

  function automatic int gq_pack();
    int v = 0;
    for (int k = 0; k < gq.size(); k++) v = v | (gq[k] << (4 * k));
    return v;
  endfunction

  task automatic load(input int i, input int len, input int cnt);
    plen[i] = len; cfg_len[i] = len; npk[i] = cnt - 1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rnd_mode) begin
        en[i] = ($urandom_range(3) != 0);
        if (plen[i] == 0 && $urandom_range(2) == 0) plen[i] = $urandom_range(6, 1);
      end
      req_valid[i] = en[i] && (plen[i] > 0);
      req_last[i]  = (plen[i] == 1);
      req_data[i*DW +: DW] = {8'(i), 8'(pk[i]), 16'(bidx[i])};
    end
    out_ready = rnd_mode ? ($urandom_range(3) != 0) : ordy_dir;
  endtask

  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    bit exp_ov, xfer, elast, forced;
    int p, g;
    drive();
    #1;
    chk("busy", busy, m_locked);
    if (m_locked) chk("grant_id", grant_id, m_grant);
    exp_ov = m_locked && req_valid[m_grant];
    chk("out_valid", out_valid, exp_ov);
    exp_rdy = '0;
    if (m_locked) exp_rdy[m_grant] = out_ready;
    chk("req_ready", req_ready, exp_rdy);
    chk("err_overlen", err_overlen, m_err);
    if (err_overlen) n_err_seen++;
    xfer  = exp_ov && out_ready;
    elast = req_last[m_grant] || (m_cnt == MAXB - 1);
    if (exp_ov) begin
      chk("out_data", out_data, req_data[m_grant*DW +: DW]);
      chk("out_last", out_last, elast);
    end
    g = m_grant;
    forced = xfer && !req_last[m_grant] && (m_cnt == MAXB - 1);
    m_err = forced;
    if (!m_locked) begin
      if (req_valid != '0) begin
        p = 0;
        for (int k = 1; k <= NREQ; k++) begin
          p = (m_last + k) % NREQ;
          if (req_valid[p]) break;
        end
        m_grant = p; m_cnt = 0; m_locked = 1'b1;
        gq.push_back(p);
      end
    end else if (xfer) begin
      m_cnt++;
      if (elast) begin m_locked = 1'b0; m_last = m_grant; end
    end
    @(posedge clk);
    if (xfer) begin
      bidx[g]++; plen[g]--;
      if (plen[g] == 0) begin
        pk[g]++; bidx[g] = 0;
        if (npk[g] > 0) begin npk[g]--; plen[g] = cfg_len[g]; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '1; req_last = '0; req_data = '0; out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      plen[i] = 0; npk[i] = 0; bidx[i] = 0; pk[i] = 0; en[i] = 1'b1;
    end
    model_reset();
    n_err_seen = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_err", err_overlen, 1'b0);
    req_valid = '0;
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic       busy;
    logic [1:0] gid;
    logic       ov;
    logic [3:0] rdy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // All four requesters hold single-beat packets: grants rotate 0,1,2,3,0 with an idle cycle each
    tbl[0] = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[1] = '{4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[2] = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[3] = '{4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2};
    tbl[4] = '{4'hF, 1'b1, 1'b0, 2'd1, 1'b0, 4'h0};
    tbl[5] = '{4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 4'h4};
    tbl[6] = '{4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0};
    tbl[7] = '{4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 4'h8};
    tbl[8] = '{4'hF, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0};
    tbl[9] = '{4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};

    do_reset();
    req_last = '1;
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].valid;
      out_ready = tbl[i].ordy;
      #1;
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_grant_id", grant_id, tbl[i].gid);
      chk("tbl_out_valid", out_valid, tbl[i].ov);
      chk("tbl_req_ready", req_ready, tbl[i].rdy);
      if (tbl[i].ov) begin
        chk("tbl_out_data", out_data, 32'hA0 + 32'(tbl[i].gid));
        chk("tbl_out_last", out_last, 1'b1);
      end
      @(posedge clk); @(negedge clk);
    end

    // Requesters 0 and 2, 3-beat packets: grants 0,2,0 with one idle bubble each
    do_reset();
    ordy_dir = 1'b1;
    load(0, 3, 2); load(2, 3, 1);
    repeat (12) cycle();
    chk("seq035_ngrants", gq.size(), 3);
    chk("seq035_order", gq_pack(), 32'h020);
    chk("seq035_drained", plen[0] + plen[2] + npk[0], 0);

    // Backpressure on requester 1 while requester 3 waits
    do_reset();
    load(1, 3, 1); load(3, 1, 1);
    begin
      logic [6:0] ords;
      ords = 7'b1111011;
      for (int c = 0; c < 7; c++) begin
        ordy_dir = ords[c];
        cycle();
      end
    end
    ordy_dir = 1'b1;
    chk("seq037_order", gq_pack(), 32'h31);
    chk("seq037_drained", plen[1] + plen[3], 0);

    // Over-length packet is cut at MAXBEATS and the remainder re-arbitrated
    do_reset();
    load(2, 6, 1);
    repeat (9) cycle();
    chk("seq038_err_pulses", n_err_seen, 1);
    chk("seq038_order", gq_pack(), 32'h22);
    chk("seq038_drained", plen[2], 0);

    // Reset during the second beat of a packet
    do_reset();
    load(2, 5, 1);
    cycle(); cycle();
    drive();
    rstn = 1'b0;
    #1;
    chk("seq039_out_valid", out_valid, 1'b0);
    chk("seq039_req_ready", req_ready, 4'h0);
    chk("seq039_busy", busy, 1'b0);
    model_reset();
    @(posedge clk); @(negedge clk);
    chk("seq039_grant_id", grant_id, 2'd0);
    rstn = 1'b1;
    load(1, 1, 1);
    repeat (7) cycle();
    chk("seq039_order", gq_pack(), 32'h21);
    chk("seq039_err_pulses", n_err_seen, 0);

    // Granted requester goes quiet mid-packet; lock must hold
    do_reset();
    load(0, 3, 1); load(1, 1, 1); load(2, 1, 1);
    cycle(); cycle();
    en[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("seq040_busy", busy, 1'b1);
      chk("seq040_grant_id", grant_id, 2'd0);
    end
    en[0] = 1'b1;
    repeat (6) cycle();
    chk("seq040_order", gq_pack(), 32'h210);
    chk("seq040_ngrants", gq.size(), 3);

    // Random traffic: valid bubbles, backpressure, packets up to 6 beats
    do_reset();
    rnd_mode = 1'b1;
    repeat (3000) cycle();
    rnd_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
